// File: rtl/pe_net_interface.sv
// Leaf-side adapter between one processing element and one leaf port of the
// butterfly-tree NoC. The TX FIFO packs {dest, payload} flits toward the switch.
// The RX FIFO keeps payloads of flits addressed to this PE. Saturating traffic
// counters and a sticky misroute flag sit alongside both paths.
module pe_net_interface #(
  parameter int DataWidth = 36,
  parameter int AddrWidth = 4,
  parameter int PeAddr    = 0,
  parameter int FifoDepth = 4
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [AddrWidth-1:0]           i_pe_dest,
  input  logic [DataWidth-AddrWidth-1:0] i_pe_payload,
  input  logic                           i_pe_valid,
  output logic                           o_pe_ready,
  output logic [DataWidth-1:0]           o_net_data,
  output logic                           o_net_data_valid,
  input  logic                           i_net_data_ready,
  input  logic [DataWidth-1:0]           i_net_data,
  input  logic                           i_net_data_valid,
  output logic                           o_net_data_ready,
  output logic [DataWidth-AddrWidth-1:0] o_pe_rx_payload,
  output logic                           o_pe_rx_valid,
  input  logic                           i_pe_rx_ready,
  input  logic                           i_clear_stats,
  output logic [15:0]                    o_tx_count,
  output logic [15:0]                    o_rx_count,
  output logic                           o_misroute
);

  localparam int PayloadWidth = DataWidth - AddrWidth;
  localparam int IdxWidth     = $clog2(FifoDepth);
  localparam int PtrWidth     = IdxWidth + 1;
  localparam logic [AddrWidth-1:0] PeAddrBits = AddrWidth'(PeAddr);

  // The extra pointer MSB tells full (MSBs differ) apart from empty (equal).
  function automatic logic isFull(input logic [PtrWidth-1:0] wr,
                                  input logic [PtrWidth-1:0] rd);
    return (wr[IdxWidth] != rd[IdxWidth]) &&
           (wr[IdxWidth-1:0] == rd[IdxWidth-1:0]);
  endfunction

  logic [DataWidth-1:0]    txMem [FifoDepth];
  logic [PayloadWidth-1:0] rxMem [FifoDepth];

  logic [PtrWidth-1:0] txWrPtrReg, txRdPtrReg, rxWrPtrReg, rxRdPtrReg;
  logic [PtrWidth-1:0] txWrPtrNext, txRdPtrNext, rxWrPtrNext, rxRdPtrNext;
  logic                peReadyReg, netReadyReg;
  logic [15:0]         txCountReg, rxCountReg;
  logic                misrouteReg;

  logic txEmpty, rxEmpty;
  logic txPush, txPop, rxAccept, rxDestMatch, rxPush, rxMisroute, rxPop;

  assign txEmpty     = (txWrPtrReg == txRdPtrReg);
  assign rxEmpty     = (rxWrPtrReg == rxRdPtrReg);
  assign txPush      = i_pe_valid & peReadyReg;
  assign txPop       = ~txEmpty & i_net_data_ready;
  assign rxAccept    = i_net_data_valid & netReadyReg;
  assign rxDestMatch = (i_net_data[DataWidth-1 -: AddrWidth] == PeAddrBits);
  assign rxPush      = rxAccept & rxDestMatch;
  // Misrouted flits are still handshaken so the switch never stalls on them.
  assign rxMisroute  = rxAccept & ~rxDestMatch;
  assign rxPop       = ~rxEmpty & i_pe_rx_ready;

  // Next pointer values; the registered readies are derived from them.
  always_comb begin
    txWrPtrNext = txWrPtrReg + PtrWidth'(txPush);
    txRdPtrNext = txRdPtrReg + PtrWidth'(txPop);
    rxWrPtrNext = rxWrPtrReg + PtrWidth'(rxPush);
    rxRdPtrNext = rxRdPtrReg + PtrWidth'(rxPop);
  end

  // Pointers and registered ready flags; readies stay low while in reset.
  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      txWrPtrReg  <= '0;
      txRdPtrReg  <= '0;
      rxWrPtrReg  <= '0;
      rxRdPtrReg  <= '0;
      peReadyReg  <= 1'b0;
      netReadyReg <= 1'b0;
    end else begin
      txWrPtrReg  <= txWrPtrNext;
      txRdPtrReg  <= txRdPtrNext;
      rxWrPtrReg  <= rxWrPtrNext;
      rxRdPtrReg  <= rxRdPtrNext;
      peReadyReg  <= ~isFull(txWrPtrNext, txRdPtrNext);
      netReadyReg <= ~isFull(rxWrPtrNext, rxRdPtrNext);
    end
  end

  // FIFO storage writes; contents are meaningless once pointers are reset.
  always_ff @(posedge i_sclk) begin
    if (txPush) txMem[txWrPtrReg[IdxWidth-1:0]] <= {i_pe_dest, i_pe_payload};
    if (rxPush) rxMem[rxWrPtrReg[IdxWidth-1:0]] <= i_net_data[PayloadWidth-1:0];
  end

  // Saturating counters and sticky misroute; clear wins over same-cycle events.
  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      txCountReg  <= '0;
      rxCountReg  <= '0;
      misrouteReg <= 1'b0;
    end else if (i_clear_stats) begin
      txCountReg  <= '0;
      rxCountReg  <= '0;
      misrouteReg <= 1'b0;
    end else begin
      if (txPop && txCountReg != 16'hFFFF) txCountReg <= txCountReg + 16'd1;
      if (rxPush && rxCountReg != 16'hFFFF) rxCountReg <= rxCountReg + 16'd1;
      if (rxMisroute) misrouteReg <= 1'b1;
    end
  end

  // First-word-fall-through heads, forced to zero when the FIFO is empty.
  assign o_net_data       = txEmpty ? '0 : txMem[txRdPtrReg[IdxWidth-1:0]];
  assign o_net_data_valid = ~txEmpty;
  assign o_pe_rx_payload  = rxEmpty ? '0 : rxMem[rxRdPtrReg[IdxWidth-1:0]];
  assign o_pe_rx_valid    = ~rxEmpty;
  assign o_pe_ready       = peReadyReg;
  assign o_net_data_ready = netReadyReg;
  assign o_tx_count       = txCountReg;
  assign o_rx_count       = rxCountReg;
  assign o_misroute       = misrouteReg;

endmodule
